// File: rtl/io_input_ctrl.sv
// io_input_ctrl: switch/button input controller for the single-cycle core.
// Every switch and button channel is synchronised and debounced. Each button
// also keeps sticky press/release flags. The LSU reads these through a
// four-word register window with registered read data.
module io_input_ctrl #(
    parameter int SW_W      = 32,
    parameter int BTN_W     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SW_W-1:0]   i_io_sw,
    input  logic [BTN_W-1:0]  i_io_btn,
    input  logic [3:0]        i_lsu_addr,
    input  logic              i_lsu_rd,
    input  logic              i_lsu_wr,
    input  logic [31:0]       i_lsu_wdata,
    output logic [31:0]       o_lsu_rdata,
    output logic              o_lsu_rvalid,
    output logic [SW_W-1:0]   o_sw_db,
    output logic [BTN_W-1:0]  o_btn_db,
    output logic              o_btn_evt
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    // Switches and buttons share one channel vector; buttons occupy the top bits.
    localparam int CH = SW_W + BTN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CH-1:0]    raw_in;
    logic [CH-1:0]    sync1;
    logic [CH-1:0]    sync2;
    logic [CH-1:0]    db_q;
    logic [CH-1:0]    db_n;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_n [CH];

    logic [BTN_W-1:0] btn_old;
    logic [BTN_W-1:0] btn_new;
    logic [BTN_W-1:0] press_q;
    logic [BTN_W-1:0] release_q;
    logic [BTN_W-1:0] press_n;
    logic [BTN_W-1:0] release_n;
    logic [BTN_W-1:0] press_clr;
    logic [BTN_W-1:0] release_clr;
    logic [1:0]       word_sel;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign raw_in      = {i_io_btn, i_io_sw};
    assign word_sel    = i_lsu_addr[3:2];
    assign btn_old     = db_q[CH-1:SW_W];
    assign btn_new     = db_n[CH-1:SW_W];
    assign o_sw_db     = db_q[SW_W-1:0];
    assign o_btn_db    = btn_old;
    // Byte-lane bits of the address and write data above the button count carry no meaning.
    assign unused_bits = &{1'b0, i_lsu_addr[1:0], i_lsu_wdata};

    // Two-flop synchroniser per channel, nothing between the stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: the level only follows sync2 after DB_CYCLES stable cycles.
    always_comb begin
        db_n = db_q;
        for (int i = 0; i < CH; i++) begin
            cnt_n[i] = '0;
            if (sync2[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_n[i] = sync2[i];
                end else begin
                    cnt_n[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce level and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            db_q <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_n;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_n[i];
            end
        end
    end

    // Sticky flag next-state: a hardware edge wins over a same-cycle W1C.
    always_comb begin
        press_clr   = '0;
        release_clr = '0;
        if (i_lsu_wr && (word_sel == 2'd2)) begin
            press_clr = i_lsu_wdata[BTN_W-1:0];
        end
        if (i_lsu_wr && (word_sel == 2'd3)) begin
            release_clr = i_lsu_wdata[BTN_W-1:0];
        end
        press_n   = (press_q & ~press_clr) | (btn_new & ~btn_old);
        release_n = (release_q & ~release_clr) | (btn_old & ~btn_new);
    end

    // Register window read mux, built from pre-edge state.
    always_comb begin
        rd_mux = '0;
        case (word_sel)
            2'd0:    rd_mux[SW_W-1:0]  = db_q[SW_W-1:0];
            2'd1:    rd_mux[BTN_W-1:0] = btn_old;
            2'd2:    rd_mux[BTN_W-1:0] = press_q;
            default: rd_mux[BTN_W-1:0] = release_q;
        endcase
    end

    // Flags, event summary and registered LSU read port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            press_q      <= '0;
            release_q    <= '0;
            o_btn_evt    <= 1'b0;
            o_lsu_rvalid <= 1'b0;
            o_lsu_rdata  <= '0;
        end else begin
            press_q      <= press_n;
            release_q    <= release_n;
            o_btn_evt    <= |(press_n | release_n);
            o_lsu_rvalid <= i_lsu_rd;
            if (i_lsu_rd) begin
                o_lsu_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl with DB_CYCLES=4.
module tb_io_input_ctrl;

    localparam int SW_W  = 32;
    localparam int BTN_W = 4;
    localparam int DB    = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [SW_W-1:0]   i_io_sw;
    logic [BTN_W-1:0]  i_io_btn;
    logic [3:0]        i_lsu_addr;
    logic              i_lsu_rd;
    logic              i_lsu_wr;
    logic [31:0]       i_lsu_wdata;
    logic [31:0]       o_lsu_rdata;
    logic              o_lsu_rvalid;
    logic [SW_W-1:0]   o_sw_db;
    logic [BTN_W-1:0]  o_btn_db;
    logic              o_btn_evt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] sb_exp;
    bit          mon_en = 1'b0;

    io_input_ctrl #(.SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_io_sw     (i_io_sw),
        .i_io_btn    (i_io_btn),
        .i_lsu_addr  (i_lsu_addr),
        .i_lsu_rd    (i_lsu_rd),
        .i_lsu_wr    (i_lsu_wr),
        .i_lsu_wdata (i_lsu_wdata),
        .o_lsu_rdata (o_lsu_rdata),
        .o_lsu_rvalid(o_lsu_rvalid),
        .o_sw_db     (o_sw_db),
        .o_btn_db    (o_btn_db),
        .o_btn_evt   (o_btn_evt)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [SW_W-1:0] sw, input logic [BTN_W-1:0] btn);
        i_io_sw  = sw;
        i_io_btn = btn;
    endtask

    task automatic lsuRead(input logic [3:0] addr, input logic [31:0] exp_data);
        i_lsu_addr = addr;
        i_lsu_rd   = 1'b1;
        @(posedge i_clk);
        sb.push_back(exp_data);
        #1;
        i_lsu_rd = 1'b0;
    endtask

    task automatic lsuWrite(input logic [3:0] addr, input logic [31:0] data);
        i_lsu_addr  = addr;
        i_lsu_wdata = data;
        i_lsu_wr    = 1'b1;
        step(1);
        i_lsu_wr = 1'b0;
    endtask

    task automatic lsuReadWrite(input logic [3:0] addr, input logic [31:0] data, input logic [31:0] exp_data);
        i_lsu_addr  = addr;
        i_lsu_wdata = data;
        i_lsu_wr    = 1'b1;
        i_lsu_rd    = 1'b1;
        @(posedge i_clk);
        sb.push_back(exp_data);
        #1;
        i_lsu_wr = 1'b0;
        i_lsu_rd = 1'b0;
    endtask

    // Scoreboard: every read pushed before an edge must show up as rvalid after it.
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (sb.size() > 0) begin
                sb_exp = sb.pop_front();
                checkOutput("rvalid", 32'(o_lsu_rvalid), 32'd1);
                checkOutput("rdata", o_lsu_rdata, sb_exp);
            end else begin
                checkOutput("rvalid_idle", 32'(o_lsu_rvalid), 32'd0);
            end
        end
    end

    initial begin
        i_rst       = 1'b1;
        i_lsu_addr  = '0;
        i_lsu_rd    = 1'b0;
        i_lsu_wr    = 1'b0;
        i_lsu_wdata = '0;
        applyStimulus(32'hFFFF_FFFF, 4'b0000);

        // 1. Reset and first debounce latency
        $display("[TB] reset and latency");
        step(1);
        mon_en = 1'b1;
        checkOutput("rst_sw_db", o_sw_db, 32'h0);
        checkOutput("rst_btn_db", 32'(o_btn_db), 32'h0);
        checkOutput("rst_evt", 32'(o_btn_evt), 32'h0);
        checkOutput("rst_rdata", o_lsu_rdata, 32'h0);
        step(1);
        checkOutput("rst_sw_db2", o_sw_db, 32'h0);
        i_rst = 1'b0;
        step(DB + 1);
        checkOutput("sw_db_early", o_sw_db, 32'h0);
        step(1);
        checkOutput("sw_db_settled", o_sw_db, 32'hFFFF_FFFF);

        // 2. Glitch rejection, then a pulse just long enough
        $display("[TB] glitch rejection");
        applyStimulus(32'hFFFF_FFFF, 4'b0001);
        step(DB - 1);
        applyStimulus(32'hFFFF_FFFF, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            checkOutput("glitch_btn_db", 32'(o_btn_db), 32'h0);
        end
        checkOutput("glitch_evt", 32'(o_btn_evt), 32'h0);
        lsuRead(4'h8, 32'h0);
        applyStimulus(32'hFFFF_FFFF, 4'b0001);
        step(DB);
        applyStimulus(32'hFFFF_FFFF, 4'b0000);
        step(1);
        checkOutput("pulse_db_before", 32'(o_btn_db), 32'h0);
        step(1);
        checkOutput("pulse_db_high", 32'(o_btn_db), 32'h1);
        checkOutput("pulse_evt", 32'(o_btn_evt), 32'h1);
        step(DB);
        checkOutput("pulse_db_low", 32'(o_btn_db), 32'h0);
        lsuRead(4'h8, 32'h1);
        lsuRead(4'hC, 32'h1);
        lsuWrite(4'h8, 32'hFFFF_FFFF);
        checkOutput("evt_release_pending", 32'(o_btn_evt), 32'h1);
        lsuWrite(4'hC, 32'hFFFF_FFFF);
        checkOutput("evt_cleared", 32'(o_btn_evt), 32'h0);

        // 3. Register reads, back to back
        $display("[TB] register reads");
        applyStimulus(32'hFFFF_FFFF, 4'b1010);
        step(DB + 4);
        checkOutput("btn_db_A", 32'(o_btn_db), 32'hA);
        lsuRead(4'h4, 32'hA);
        lsuRead(4'h8, 32'hA);
        lsuRead(4'h8, 32'hA);
        lsuRead(4'h0, 32'hFFFF_FFFF);
        lsuRead(4'hC, 32'h0);
        lsuRead(4'h4, 32'hA);
        step(3);
        checkOutput("rdata_hold", o_lsu_rdata, 32'hA);

        // 4. W1C behaviour and read-only registers
        $display("[TB] write-one-to-clear");
        lsuWrite(4'h8, 32'h2);
        lsuRead(4'h8, 32'h8);
        checkOutput("evt_press_left", 32'(o_btn_evt), 32'h1);
        lsuWrite(4'h0, 32'h0);
        lsuWrite(4'h4, 32'h0);
        lsuRead(4'h0, 32'hFFFF_FFFF);
        lsuRead(4'h4, 32'hA);
        applyStimulus(32'hFFFF_FFFF, 4'b0000);
        step(DB + 4);
        lsuRead(4'hC, 32'hA);
        lsuRead(4'h8, 32'h8);
        lsuWrite(4'h8, 32'hFFFF_FFFF);
        lsuRead(4'h8, 32'h0);
        checkOutput("evt_release_only", 32'(o_btn_evt), 32'h1);
        lsuWrite(4'hC, 32'hFFFF_FFFF);
        checkOutput("evt_all_clear", 32'(o_btn_evt), 32'h0);

        // 5. Set/clear collision and simultaneous read+write
        $display("[TB] collision");
        applyStimulus(32'hFFFF_FFFF, 4'b0010);
        step(DB + 1);
        lsuReadWrite(4'h8, 32'h2, 32'h0);
        checkOutput("coll_btn_db", 32'(o_btn_db), 32'h2);
        checkOutput("coll_evt", 32'(o_btn_evt), 32'h1);
        lsuRead(4'h8, 32'h2);
        lsuReadWrite(4'h8, 32'h2, 32'h2);
        lsuRead(4'h8, 32'h0);
        checkOutput("rw_evt", 32'(o_btn_evt), 32'h0);

        // 6. Reset mid-operation
        $display("[TB] reset mid-operation");
        applyStimulus(32'hFFFF_FFFF, 4'b1111);
        step(DB + 4);
        lsuRead(4'h8, 32'hD);
        applyStimulus(32'hFFFF_FFFF, 4'b0000);
        step(3);
        i_rst = 1'b1;
        step(1);
        checkOutput("mid_rst_btn_db", 32'(o_btn_db), 32'h0);
        checkOutput("mid_rst_sw_db", o_sw_db, 32'h0);
        checkOutput("mid_rst_evt", 32'(o_btn_evt), 32'h0);
        checkOutput("mid_rst_rdata", o_lsu_rdata, 32'h0);
        i_rst = 1'b0;
        applyStimulus(32'hFFFF_FFFF, 4'b1111);
        step(DB + 1);
        checkOutput("redb_btn_early", 32'(o_btn_db), 32'h0);
        checkOutput("redb_sw_early", o_sw_db, 32'h0);
        step(1);
        checkOutput("redb_btn", 32'(o_btn_db), 32'hF);
        checkOutput("redb_sw", o_sw_db, 32'hFFFF_FFFF);
        lsuRead(4'h8, 32'hF);
        lsuRead(4'hC, 32'h0);
        checkOutput("redb_evt", 32'(o_btn_evt), 32'h1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            step(1);
        end
        step(1);
        checkOutput("sb_drain", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
Parametrised memory-mapped input controller for the single-cycle core's switch and button I/O. It synchronises and debounces every switch and button channel, and latches sticky press/release events per button. Debounced levels and events are exposed to the LSU through a small register window with registered read data. It replaces direct raw wiring of i_io_sw/i_io_btn into the LSU read mux.

Parameters:
SW_W, 32, number of switch channels (1..32)
BTN_W, 4, number of button channels (1..32)
DB_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=1)
CNT_W, $clog2(DB_CYCLES+1), debounce counter width (derived; not overridden)

Ports:
i_clk  input  1  clock, all flops rising-edge
i_rst  input  1  synchronous active-high reset
i_io_sw  input  SW_W  raw asynchronous switch inputs
i_io_btn  input  BTN_W  raw asynchronous button inputs (1 = pressed)
i_lsu_addr  input  4  byte offset in window; bits [1:0] ignored
i_lsu_rd  input  1  read strobe, one cycle per access
i_lsu_wr  input  1  write strobe
i_lsu_wdata  input  32  write data
o_lsu_rdata  output  32  registered read data
o_lsu_rvalid  output  1  one-cycle pulse, read data valid
o_sw_db  output  SW_W  debounced switch levels
o_btn_db  output  BTN_W  debounced button levels
o_btn_evt  output  1  OR of all pending press and release flags

Behaviour:
- Reset (sync, i_rst=1 at a rising edge): synchroniser flops, counters, o_sw_db, o_btn_db, press/release flags, o_lsu_rdata, o_lsu_rvalid, o_btn_evt all 0. Reset mid-debounce or with flags pending discards all state. Strobes are ignored while i_rst=1.
- Synchroniser: 2 flops per channel (s1, s2). No logic between s1 and s2.
- Debounce, per channel, each cycle:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce timing: a clean input change sampled at edge k appears on db after edge k+1+DB_CYCLES. Total latency is 2+DB_CYCLES-1 edges after the s1 capture.
- Glitch rejection: any pulse shorter than DB_CYCLES cycles at s2 never changes db, and its counter returns to 0.
- Events, per button: press[i] sets when db[i] goes 0->1; release[i] sets when db[i] goes 1->0. Flags are sticky.
- Register map (word offset = i_lsu_addr[3:2]):
  - 0x0 SW_LEVEL (RO): zero-extended o_sw_db.
  - 0x4 BTN_LEVEL (RO): zero-extended o_btn_db.
  - 0x8 BTN_PRESS (W1C).
  - 0xC BTN_RELEASE (W1C).
- Writes to RO registers are ignored. W1C only affects bits [BTN_W-1:0]. Writing 0 bits leaves flags unchanged.
- Set/clear collision: a hardware set and a W1C of the same bit in the same cycle leaves the bit set.
- Reads: i_lsu_rd at edge t captures the register value as it was before edge t's updates. o_lsu_rdata and o_lsu_rvalid=1 are valid after edge t. o_lsu_rvalid drops after the next edge unless another read occurs. o_lsu_rdata holds its last value between reads.
- Back-to-back reads every cycle are supported with 1-cycle latency each.
- i_lsu_rd and i_lsu_wr together: both are performed. Read data is the pre-write value.
- Reads do not clear flags.
- o_btn_evt is registered from the flag state: it is |(press|release) after each edge.

Test Plan:
1. Reset, DB_CYCLES=4: assert i_rst 2 cycles with i_io_sw=32'hFFFFFFFF -> all outputs 0 during reset. o_sw_db=32'hFFFFFFFF exactly 5 edges after the first post-reset edge.
2. Glitch: btn[0] high for 3 cycles, then low -> o_btn_db stays 0, BTN_PRESS reads 0, o_btn_evt stays 0. A 4-cycle pulse -> o_btn_db[0] pulses, press[0]=1, release[0]=1, o_btn_evt=1.
3. Register read: i_io_btn=4'b1010 held stable, then read 0x4 -> o_lsu_rvalid pulses one cycle after the strobe with rdata=32'h0000000A. Read 0x8 -> 32'h0000000A. Reading 0x8 again still returns 32'h0000000A.
4. W1C: flags press=4'b1010, write 0x8 with wdata 32'h00000002 -> press=4'b1000. Write 32'hFFFFFFFF -> press=0. o_btn_evt clears only when release is also 0.
5. Collision: W1C press[1] on the same edge btn[1] debounces 0->1 -> press[1] remains 1. A simultaneous read of 0x8 returns the pre-edge value.
6. Reset mid-operation: pending press flags, counters mid-count, i_rst for one cycle -> flags 0, o_btn_db 0. Re-debounce completes after the full 2+DB_CYCLES latency.
